register_bank_arbiter: RTL and testbench

Per-cycle arbiter for the single-ported register banks inside the register operand-collector stage. Grants each bank to at most one requester per cycle: operand-collector reads or the execution-unit writeback. Reads use a per-bank round-robin; writeback has a starvation guard. Read data is routed back to the granting collector with fixed one-cycle latency.

---
 rtl/bgpu_pkg.sv | 31 +++
 rtl/bank_rr_arbiter.sv | 39 +++
 rtl/register_bank_arbiter.sv | 98 +++++++++
 tb/tb_register_bank_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bgpu_pkg.sv
// bgpu_pkg: shared types and bank mapping for the register operand-collector stage.
package bgpu_pkg;
  localparam int NumBanks = 4;
  localparam int NumOperandCollectors = 6;
  localparam int NumWarps = 8;
  localparam int RegIdxWidth = 8;
  localparam int RegWidth = 32;
  localparam int WarpWidth = 4;
  localparam int MaxWbStall = 3;
  localparam int WidWidth = $clog2(NumWarps);
  localparam int BankIdxWidth = $clog2(NumBanks);
  localparam int BankAddrWidth = WidWidth + RegIdxWidth - BankIdxWidth;
  localparam int OpcIdxWidth = $clog2(NumOperandCollectors);
  localparam int StallWidth = $clog2(MaxWbStall + 1);
  localparam int DataWidth = RegWidth * WarpWidth;

  typedef logic [WidWidth-1:0] wid_t;
  typedef logic [RegIdxWidth-1:0] reg_idx_t;
  typedef logic [DataWidth-1:0] reg_data_t;
  typedef logic [BankIdxWidth-1:0] bank_idx_t;
  typedef logic [BankAddrWidth-1:0] bank_addr_t;
  typedef logic [OpcIdxWidth-1:0] opc_idx_t;

  function automatic bank_idx_t bank_of(input wid_t wid, input reg_idx_t r);
    return bank_idx_t'((int'(r) + int'(wid)) % NumBanks);
  endfunction

  function automatic bank_addr_t bank_addr_of(input wid_t wid, input reg_idx_t r);
    return bank_addr_t'({wid, r} >> BankIdxWidth);
  endfunction
endpackage

// File: rtl/bank_rr_arbiter.sv
// bank_rr_arbiter: one bank's grant, round-robin among reads with a starvation-guarded writeback.
module bank_rr_arbiter
  import bgpu_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumOperandCollectors-1:0] rd_req_i,
  input  logic                            wb_req_i,
  input  logic [StallWidth-1:0]           wb_stall_i,
  output logic [NumOperandCollectors-1:0] rd_gnt_o,
  output logic [OpcIdxWidth-1:0]          rd_idx_o,
  output logic                            rd_vld_o,
  output logic                            wb_gnt_o
);
  opc_idx_t rr_q, rr_d, pick, j;
  logic found;
  always_comb begin
    pick = rr_q;
    j = rr_q;
    found = 1'b0;
    for (int k = 0; k < NumOperandCollectors; k++) begin
      j = opc_idx_t'((int'(rr_q) + k) % NumOperandCollectors);
      if (!found && rd_req_i[j]) begin
        found = 1'b1;
        pick = j;
      end
    end
    wb_gnt_o = wb_req_i && (!(|rd_req_i) || wb_stall_i >= StallWidth'(MaxWbStall));
    rd_vld_o = found && !wb_gnt_o;
    rd_idx_o = pick;
    rd_gnt_o = '0;
    if (rd_vld_o) rd_gnt_o[pick] = 1'b1;
    rr_d = !rd_vld_o ? rr_q : pick == opc_idx_t'(NumOperandCollectors - 1) ? '0 : pick + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rr_q <= '0;
    else rr_q <= rr_d;
  end
endmodule

// File: rtl/register_bank_arbiter.sv
// register_bank_arbiter: grants single-ported register banks to collector reads or the writeback
// and routes read data back to the granted collector one cycle later.
module register_bank_arbiter
  import bgpu_pkg::*;
(
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NumOperandCollectors-1:0]             opc_valid_i,
  output logic [NumOperandCollectors-1:0]             opc_ready_o,
  input  logic [NumOperandCollectors*WidWidth-1:0]    opc_wid_i,
  input  logic [NumOperandCollectors*RegIdxWidth-1:0] opc_reg_i,
  output logic [NumOperandCollectors-1:0]             opc_rsp_valid_o,
  output logic [NumOperandCollectors*DataWidth-1:0]   opc_rsp_data_o,
  input  logic                                        eu_valid_i,
  output logic                                        eu_ready_o,
  input  logic [WidWidth-1:0]                         eu_wid_i,
  input  logic [RegIdxWidth-1:0]                      eu_dst_i,
  input  logic [DataWidth-1:0]                        eu_data_i,
  output logic [NumBanks-1:0]                         bank_req_o,
  output logic [NumBanks-1:0]                         bank_we_o,
  output logic [NumBanks*BankAddrWidth-1:0]           bank_addr_o,
  output logic [NumBanks*DataWidth-1:0]               bank_wdata_o,
  input  logic [NumBanks*DataWidth-1:0]               bank_rdata_i
);
  bank_idx_t opc_bank [NumOperandCollectors];
  bank_addr_t opc_addr [NumOperandCollectors];
  logic [NumOperandCollectors-1:0] rd_req [NumBanks];
  logic [NumOperandCollectors-1:0] rd_gnt [NumBanks];
  opc_idx_t rd_idx [NumBanks];
  opc_idx_t rsp_idx_q [NumBanks];
  logic [NumBanks-1:0] rd_vld, wb_req, wb_gnt, rsp_vld_q;
  logic [StallWidth-1:0] wb_stall_q, wb_stall_d;
  bank_idx_t eu_bank;
  bank_addr_t eu_addr;

  assign eu_bank = bank_of(eu_wid_i, eu_dst_i);
  assign eu_addr = bank_addr_of(eu_wid_i, eu_dst_i);
  assign eu_ready_o = |wb_gnt;

  for (genvar c = 0; c < NumOperandCollectors; c++) begin : g_opc
    assign opc_bank[c] = bank_of(opc_wid_i[c*WidWidth +: WidWidth], opc_reg_i[c*RegIdxWidth +: RegIdxWidth]);
    assign opc_addr[c] = bank_addr_of(opc_wid_i[c*WidWidth +: WidWidth], opc_reg_i[c*RegIdxWidth +: RegIdxWidth]);
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    for (genvar c = 0; c < NumOperandCollectors; c++) begin : g_req
      assign rd_req[b][c] = opc_valid_i[c] && opc_bank[c] == bank_idx_t'(b);
    end
    assign wb_req[b] = eu_valid_i && eu_bank == bank_idx_t'(b);
    bank_rr_arbiter u_arb (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .rd_req_i   (rd_req[b]),
      .wb_req_i   (wb_req[b]),
      .wb_stall_i (wb_stall_q),
      .rd_gnt_o   (rd_gnt[b]),
      .rd_idx_o   (rd_idx[b]),
      .rd_vld_o   (rd_vld[b]),
      .wb_gnt_o   (wb_gnt[b])
    );
    assign bank_req_o[b] = rd_vld[b] | wb_gnt[b];
    assign bank_we_o[b] = wb_gnt[b];
    assign bank_addr_o[b*BankAddrWidth +: BankAddrWidth] = wb_gnt[b] ? eu_addr : rd_vld[b] ? opc_addr[rd_idx[b]] : '0;
    assign bank_wdata_o[b*DataWidth +: DataWidth] = wb_gnt[b] ? eu_data_i : '0;
  end

  always_comb begin
    opc_ready_o = '0;
    for (int b = 0; b < NumBanks; b++) opc_ready_o = opc_ready_o | rd_gnt[b];
  end

  // The stall count only tracks a writeback that is continuously waiting.
  assign wb_stall_d = (!eu_valid_i || eu_ready_o) ? '0 :
                      wb_stall_q == StallWidth'(MaxWbStall) ? wb_stall_q : wb_stall_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_stall_q <= '0;
      rsp_vld_q <= '0;
      for (int b = 0; b < NumBanks; b++) rsp_idx_q[b] <= '0;
    end else begin
      wb_stall_q <= wb_stall_d;
      rsp_vld_q <= rd_vld;
      rsp_idx_q <= rd_idx;
    end
  end

  always_comb begin
    opc_rsp_valid_o = '0;
    opc_rsp_data_o = '0;
    for (int b = 0; b < NumBanks; b++) begin
      if (rsp_vld_q[b]) begin
        opc_rsp_valid_o[rsp_idx_q[b]] = 1'b1;
        opc_rsp_data_o[int'(rsp_idx_q[b])*DataWidth +: DataWidth] = bank_rdata_i[b*DataWidth +: DataWidth];
      end
    end
  end
endmodule

// File: tb/tb_register_bank_arbiter.sv
// tb_register_bank_arbiter: directed and randomized checks against a register-file level model.
module tb_register_bank_arbiter;
  import bgpu_pkg::*;
  localparam int NB = NumBanks;
  localparam int NC = NumOperandCollectors;
  localparam int DW = DataWidth;
  localparam int AW = BankAddrWidth;
  localparam int NR = 1 << RegIdxWidth;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0] opc_valid, opc_ready, rsp_valid;
  logic [NC*WidWidth-1:0] opc_wid;
  logic [NC*RegIdxWidth-1:0] opc_reg;
  logic [NC*DW-1:0] rsp_data;
  logic eu_valid, eu_ready;
  logic [WidWidth-1:0] eu_wid;
  logic [RegIdxWidth-1:0] eu_dst;
  logic [DW-1:0] eu_data;
  logic [NB-1:0] bank_req, bank_we;
  logic [NB*AW-1:0] bank_addr;
  logic [NB*DW-1:0] bank_wdata, bank_rdata;

  register_bank_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .opc_valid_i(opc_valid), .opc_ready_o(opc_ready), .opc_wid_i(opc_wid), .opc_reg_i(opc_reg),
    .opc_rsp_valid_o(rsp_valid), .opc_rsp_data_o(rsp_data),
    .eu_valid_i(eu_valid), .eu_ready_o(eu_ready), .eu_wid_i(eu_wid), .eu_dst_i(eu_dst), .eu_data_i(eu_data),
    .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
    .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata)
  );

  int vectors = 0;
  int errors = 0;
  logic [DW-1:0] rf [NumWarps][NR];
  logic [DW-1:0] mem [NB][1<<AW];
  int rr [NB];
  int stall;
  int win [NB];
  logic [NC-1:0] pend_v;
  logic [DW-1:0] pend_d [NC];
  logic [NC-1:0] x_ready, x_rsp_v, s_ready, s_rsp_v;
  logic x_eu, s_eu;
  logic [NB-1:0] x_req, x_we, s_req, s_we;
  logic [NB*AW-1:0] x_addr, s_addr;
  logic [NB*DW-1:0] x_wdata, s_wdata;
  logic [NC*DW-1:0] x_rsp_d, s_rsp_d;
  logic [NC-1:0] conf_exp [3];
  logic [DW-1:0] pat;

  task automatic check(input string tag, input logic [NC*DW-1:0] obs, input logic [NC*DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cw(input int c);
    return int'(opc_wid[c*WidWidth +: WidWidth]);
  endfunction
  function automatic int cr(input int c);
    return int'(opc_reg[c*RegIdxWidth +: RegIdxWidth]);
  endfunction
  function automatic int addr_of(input int w, input int r);
    return w * (NR / NB) + r / NB;
  endfunction

  task automatic set_opc(input int c, input int w, input int r);
    opc_valid[c] = 1'b1;
    opc_wid[c*WidWidth +: WidWidth] = WidWidth'(w);
    opc_reg[c*RegIdxWidth +: RegIdxWidth] = RegIdxWidth'(r);
  endtask

  task automatic set_wb(input int w, input int r, input logic [DW-1:0] d);
    eu_valid = 1'b1;
    eu_wid = WidWidth'(w);
    eu_dst = RegIdxWidth'(r);
    eu_data = d;
  endtask

  task automatic retire();
    opc_valid = opc_valid & ~x_ready;
    if (x_eu) eu_valid = 1'b0;
  endtask

  // One clock: predict from the model, compare at the falling edge, then advance model and banks.
  task automatic step();
    int best, bd, d, a;
    @(negedge clk);
    x_ready = '0; x_eu = 1'b0; x_req = '0; x_we = '0; x_addr = '0; x_wdata = '0;
    x_rsp_v = pend_v; x_rsp_d = '0;
    for (int c = 0; c < NC; c++) if (pend_v[c]) x_rsp_d[c*DW +: DW] = pend_d[c];
    for (int b = 0; b < NB; b++) begin
      best = -1; bd = NC;
      for (int c = 0; c < NC; c++) begin
        if (opc_valid[c] && (cr(c) + cw(c)) % NB == b) begin
          d = (c - rr[b] + NC) % NC;
          if (d < bd) begin best = c; bd = d; end
        end
      end
      win[b] = best;
      if (eu_valid && (int'(eu_dst) + int'(eu_wid)) % NB == b && (best < 0 || stall >= MaxWbStall)) win[b] = NC;
      if (win[b] == NC) begin
        x_eu = 1'b1; x_req[b] = 1'b1; x_we[b] = 1'b1;
        a = addr_of(int'(eu_wid), int'(eu_dst));
        x_addr[b*AW +: AW] = AW'(a);
        x_wdata[b*DW +: DW] = eu_data;
      end else if (best >= 0) begin
        x_ready[best] = 1'b1; x_req[b] = 1'b1;
        a = addr_of(cw(best), cr(best));
        x_addr[b*AW +: AW] = AW'(a);
      end
    end
    check("opc_ready", opc_ready, x_ready);
    check("eu_ready", eu_ready, x_eu);
    check("bank_req", bank_req, x_req);
    check("bank_we", bank_we, x_we);
    check("bank_addr", bank_addr, x_addr);
    check("bank_wdata", bank_wdata, x_wdata);
    check("rsp_valid", rsp_valid, x_rsp_v);
    check("rsp_data", rsp_data, x_rsp_d);
    s_ready = opc_ready; s_eu = eu_ready; s_req = bank_req; s_we = bank_we;
    s_addr = bank_addr; s_wdata = bank_wdata; s_rsp_v = rsp_valid; s_rsp_d = rsp_data;
    @(posedge clk);
    #1;
    pend_v = '0;
    for (int b = 0; b < NB; b++) begin
      if (!rst_ni) rr[b] = 0;
      else if (win[b] >= 0 && win[b] < NC) begin
        pend_v[win[b]] = 1'b1;
        pend_d[win[b]] = rf[cw(win[b])][cr(win[b])];
        rr[b] = (win[b] + 1) % NC;
      end
    end
    stall = (!rst_ni || !eu_valid || x_eu) ? 0 : (stall + 1 > MaxWbStall ? MaxWbStall : stall + 1);
    if (x_eu) rf[eu_wid][eu_dst] = eu_data;
    for (int b = 0; b < NB; b++) begin
      bank_rdata[b*DW +: DW] = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (s_req[b] && !s_we[b]) bank_rdata[b*DW +: DW] = mem[b][s_addr[b*AW +: AW]];
      if (s_req[b] && s_we[b]) mem[b][s_addr[b*AW +: AW]] = s_wdata[b*DW +: DW];
    end
  endtask

  initial begin
    opc_valid = '0; opc_wid = '0; opc_reg = '0;
    eu_valid = 1'b0; eu_wid = '0; eu_dst = '0; eu_data = '0; bank_rdata = '0;
    for (int w = 0; w < NumWarps; w++)
      for (int r = 0; r < NR; r++) begin
        rf[w][r] = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem[(r + w) % NB][addr_of(w, r)] = rf[w][r];
      end
    for (int b = 0; b < NB; b++) rr[b] = 0;
    stall = 0; pend_v = '0;
    conf_exp[0] = 6'b000001; conf_exp[1] = 6'b000010; conf_exp[2] = 6'b010000;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst_ni = 1'b1;
    step();

    set_opc(2, 1, 3);
    step();
    check("single_ready", s_ready, 6'b000100);
    check("single_addr", s_addr[AW-1:0], 9'h040);
    retire();
    step();
    check("single_rsp", s_rsp_v, 6'b000100);

    set_opc(0, 0, 1); set_opc(1, 0, 5); set_opc(4, 0, 9);
    for (int i = 0; i < 3; i++) begin
      step();
      check("conflict_order", s_ready, conf_exp[i]);
      retire();
    end

    for (int c = 0; c < 4; c++) set_opc(c, 0, c);
    step();
    check("parallel_ready", s_ready, 6'b001111);
    retire();
    step();
    check("parallel_rsp", s_rsp_v, 6'b001111);

    for (int k = 0; k < 2; k++) begin
      set_opc(0, 0, 2);
      set_wb(0, 6, {$urandom(), $urandom(), $urandom(), $urandom()});
      for (int i = 0; i < 4; i++) begin
        step();
        check("starve_eu_ready", s_eu, i == 3);
        if (x_eu) eu_valid = 1'b0;
      end
      opc_valid = '0;
      step();
    end

    pat = {4{32'hA5A5_A5A5}};
    set_wb(0, 5, pat);
    step();
    check("wtr_write", s_eu, 1'b1);
    retire();
    set_opc(3, 0, 5);
    step();
    retire();
    step();
    check("wtr_data", s_rsp_d[3*DW +: DW], pat);

    set_opc(1, 0, 1);
    rst_ni = 1'b0;
    step();
    retire();
    rst_ni = 1'b1;
    set_opc(0, 0, 1); set_opc(5, 0, 5);
    step();
    check("reset_rsp_dropped", s_rsp_v, 6'b000000);
    check("reset_rr", s_ready, 6'b000001);
    retire();
    opc_valid = '0;

    for (int i = 0; i < 400; i++) begin
      retire();
      for (int c = 0; c < NC; c++)
        if (!opc_valid[c] && $urandom_range(1, 0) == 1)
          set_opc(c, int'($urandom_range(NumWarps - 1, 0)), int'($urandom_range(NR - 1, 0)));
      if (!eu_valid && $urandom_range(1, 0) == 1)
        set_wb(int'($urandom_range(NumWarps - 1, 0)), int'($urandom_range(NR - 1, 0)),
               {$urandom(), $urandom(), $urandom(), $urandom()});
      rst_ni = $urandom_range(49, 0) != 0;
      step();
    end
    rst_ni = 1'b1;
    opc_valid = '0;
    eu_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
